// File: rtl/spi_master_engine.sv
// spi_master_engine: single-frame SPI master with latched mode/divider/chip-select.
// Define SPI_MASTER_MISO_SYNC_EN to pass miso_i through a 2-flop synchronizer (needs clk_div_i >= 2).
module spi_master_engine #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8,
    parameter int CS_N   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       tx_data_i,
    input  logic                    cpol_i,
    input  logic                    cpha_i,
    input  logic                    lsb_first_i,
    input  logic [DIV_W-1:0]        clk_div_i,
    input  logic [$clog2(CS_N)-1:0] cs_sel_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_W-1:0]       rx_data_o,
    output logic                    sclk_o,
    output logic                    mosi_o,
    input  logic                    miso_i,
    output logic [CS_N-1:0]         cs_n_o
);
    localparam int BW = $clog2(DATA_W);
    localparam int EW = $clog2(2 * DATA_W) + 1;
    localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;
    state_t            r_state;
    logic [DATA_W-1:0] r_tx, r_rx;
    logic [DIV_W-1:0]  r_div, r_cnt;
    logic [EW-1:0]     r_edge;
    logic [BW-1:0]     r_bit;
    logic              r_cpol, r_cpha, r_lsb;
    logic              w_tog, w_lead, w_samp, w_shft, w_cap, w_miso;
    logic [BW-1:0]     w_idx;
    // r_edge counts SCLK edges already issued, so an even count means the next edge is leading
    assign w_tog  = (r_cnt == '0) && (r_state == SETUP || (r_state == XFER && r_edge != LAST));
    assign w_lead = ~r_edge[0];
    assign w_samp = w_tog && (w_lead ^ r_cpha);
    assign w_shft = w_tog && !(w_lead ^ r_cpha) && (r_edge != LAST - EW'(1));
    assign w_idx  = r_lsb ? r_bit : BW'(DATA_W - 1) - r_bit;
`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] r_sync, r_samp_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_samp_d <= '0;
        end else begin
            r_sync   <= {r_sync[0], miso_i};
            r_samp_d <= {r_samp_d[0], w_samp};
        end
    end
    assign w_cap  = r_samp_d[1];
    assign w_miso = r_sync[1];
`else
    assign w_cap  = w_samp;
    assign w_miso = miso_i;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
            sclk_o    <= 1'b0;
            mosi_o    <= 1'b0;
            cs_n_o    <= '1;
            r_tx      <= '0;
            r_rx      <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_bit     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            r_cnt  <= (r_cnt == '0) ? r_div : r_cnt - DIV_W'(1);
            if (w_cap)
                r_rx <= r_lsb ? {w_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], w_miso};
            if (w_tog) begin
                sclk_o <= ~sclk_o;
                r_edge <= r_edge + EW'(1);
            end
            if (w_shft) begin
                mosi_o <= r_tx[w_idx];
                r_bit  <= r_bit + BW'(1);
            end
            case (r_state)
                IDLE: if (start_i) begin
                    r_state <= SETUP;
                    busy_o  <= 1'b1;
                    r_tx    <= tx_data_i;
                    r_cpol  <= cpol_i;
                    r_cpha  <= cpha_i;
                    r_lsb   <= lsb_first_i;
                    r_div   <= clk_div_i;
                    r_cnt   <= clk_div_i;
                    r_edge  <= '0;
                    r_bit   <= cpha_i ? BW'(0) : BW'(1);
                    sclk_o  <= cpol_i;
                    cs_n_o  <= ~(CS_N'(1) << cs_sel_i);
                    if (!cpha_i)
                        mosi_o <= lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
                end
                SETUP: if (r_cnt == '0) r_state <= XFER;
                XFER:  if (r_cnt == '0 && r_edge == LAST) r_state <= HOLD;
                HOLD:  if (r_cnt == '0) begin
                    r_state   <= DONE;
                    cs_n_o    <= '1;
                    done_o    <= 1'b1;
                    rx_data_o <= r_rx;
                end
                DONE: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
